timing_gen: RTL and testbench
=============================

TIMING_GEN -- requirements
Module: timing_gen

Interface
REQ-001 Parameter: OP_W, default 3, opcode field width; only 3 is supported.
REQ-002 CLK  input  1  single clock; all state updates on its rising edge.
REQ-003 RST  input  1  asynchronous active-high reset.
REQ-004 START  input  1  request to begin instruction cycles; sampled at rising edge.
REQ-005 STOP  input  1  request to halt after the current cycle completes.
REQ-006 IIR  input  1  load strobe for the opcode latch, driven by the control unit.
REQ-007 IR_OP  input  OP_W  opcode field from the instruction register.
REQ-008 T0..T7  output  1 each  one-hot beat pulses to the control unit.
REQ-009 LD, ADD, SUB, AND, OR  output  1 each  decoded instruction lines to the control unit.
REQ-010 ILL  output  1  latched opcode is illegal.
REQ-011 RUN  output  1  high while beats are being generated.
REQ-012 CYC_CNT  output  8  count of completed 8-beat cycles.

Function
REQ-013 All outputs SHALL be registered; none SHALL combinationally depend on inputs.
REQ-014 FSM states SHALL be IDLE, RUN and DRAIN.
REQ-015 IDLE: T0..T7 all 0, RUN=0; START=1 and STOP=0 at an edge -> RUN, with T0=1 and RUN=1 after that edge.
REQ-016 IDLE with START=1 and STOP=1 at the same edge SHALL remain IDLE.
REQ-017 RUN: each edge SHALL advance the beat T(n) -> T(n+1), and T7 SHALL wrap to T0; exactly one T SHALL be high in RUN and DRAIN.
REQ-018 START in RUN or DRAIN SHALL be ignored.
REQ-019 STOP=1 at any edge in RUN SHALL move the FSM to DRAIN; beats continue through T7.
REQ-020 An edge with T7 high in DRAIN SHALL clear all T and RUN and enter IDLE; STOP sampled at a T7 edge in RUN SHALL also enter IDLE directly.
REQ-021 An edge with T3 high in RUN and ILL=1 SHALL move the FSM to DRAIN.
REQ-022 CYC_CNT SHALL increment at every edge where T7 is high in RUN or DRAIN; it SHALL wrap from 255 to 0.
REQ-023 IIR=1 at an edge SHALL latch IR_OP in any state; the decode outputs SHALL reflect the new opcode after that same edge.
REQ-024 Decode: 000 none (NOP), 001 LD, 010 ADD, 011 SUB, 100 AND, 101 OR.
REQ-025 Opcodes 110 and 111 SHALL set ILL=1 with all decode lines 0.
REQ-026 At most one of LD/ADD/SUB/AND/OR/ILL SHALL be high; decode lines SHALL hold between IIR loads regardless of FSM state.

Reset
REQ-027 RST=1 SHALL immediately and asynchronously set state IDLE, T0..T7=0, opcode latch=000, LD/ADD/SUB/AND/OR=0, ILL=0, RUN=0 and CYC_CNT=0.
REQ-028 Reset asserted mid-cycle, e.g. at T4, SHALL clear all outputs without waiting for an edge; after release, no beat SHALL occur until a new START.

Verification
REQ-029 Reset, IIR with IR_OP=001, then START -> LD=1; T0..T7 walk one-hot across 8 edges; back to T0; CYC_CNT=1 after the first T7 edge.
REQ-030 In RUN with ADD latched, pulse STOP at T2 -> beats continue T3..T7; then IDLE with all T=0, RUN=0 and CYC_CNT incremented by 1.
REQ-031 IIR with IR_OP=110, then START -> ILL=1 and no decode line high; FSM enters DRAIN at the T3 edge; after T7, IDLE.
REQ-032 Run 256 full cycles -> CYC_CNT reads 0 after the 256th T7 edge.
REQ-033 START+STOP together in IDLE -> stays IDLE; START at T5 in RUN -> no effect on beat sequence.
REQ-034 Assert RST asynchronously while T4=1 and SUB=1 -> all outputs 0 before the next edge; after release, outputs stay 0 until START.

Source files
------------

// File: rtl/timing_gen.sv
// rtl/timing_gen.sv - eight-beat instruction timing generator with opcode latch and decode
//
// Purpose:
//   Produces one-hot beat pulses T0..T7 for the control unit while running,
//   counts completed 8-beat cycles, and holds a latched, decoded opcode.
//
// Ports:
//   CLK      in   clock, all state changes on the rising edge
//   RST      in   asynchronous active-high reset
//   START    in   begin generating beats (honoured only when idle)
//   STOP     in   finish the current 8-beat cycle, then go idle
//   IIR      in   load strobe for the opcode latch
//   IR_OP    in   opcode field from the instruction register
//   T0..T7   out  one-hot beat pulses
//   LD, ADD, SUB, AND, OR  out  decoded instruction lines
//   ILL      out  latched opcode is illegal (110 or 111)
//   RUN      out  high while beats are being generated
//   CYC_CNT  out  completed 8-beat cycles, modulo 256

module timing_gen #(
    parameter int OP_W = 3
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            START,
    input  logic            STOP,
    input  logic            IIR,
    input  logic [OP_W-1:0] IR_OP,
    output logic            T0,
    output logic            T1,
    output logic            T2,
    output logic            T3,
    output logic            T4,
    output logic            T5,
    output logic            T6,
    output logic            T7,
    output logic            LD,
    output logic            ADD,
    output logic            SUB,
    output logic            AND,
    output logic            OR,
    output logic            ILL,
    output logic            RUN,
    output logic [7:0]      CYC_CNT
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t          state;
    logic [7:0]      beat;
    logic [OP_W-1:0] op;

    assign {T7, T6, T5, T4, T3, T2, T1, T0} = beat;

    // Decode comes straight from the opcode register, so the lines change
    // only when the latch is loaded and never follow IR_OP directly.
    assign LD  = (op == OP_W'(1));
    assign ADD = (op == OP_W'(2));
    assign SUB = (op == OP_W'(3));
    assign AND = (op == OP_W'(4));
    assign OR  = (op == OP_W'(5));
    assign ILL = (op == OP_W'(6)) || (op == OP_W'(7));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            op <= '0;
        end else if (IIR) begin
            op <= IR_OP;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= ST_IDLE;
            beat    <= 8'd0;
            RUN     <= 1'b0;
            CYC_CNT <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // START together with STOP is treated as no request.
                    if (START && !STOP) begin
                        state <= ST_RUN;
                        beat  <= 8'b0000_0001;
                        RUN   <= 1'b1;
                    end
                end

                ST_RUN: begin
                    if (beat[7]) begin
                        CYC_CNT <= CYC_CNT + 8'd1;
                    end
                    if (STOP && beat[7]) begin
                        // Stop seen on the last beat: the cycle is already
                        // complete, so skip draining.
                        state <= ST_IDLE;
                        beat  <= 8'd0;
                        RUN   <= 1'b0;
                    end else begin
                        beat <= {beat[6:0], beat[7]};
                        // An illegal opcode aborts at mid-cycle but the
                        // remaining beats still run out.
                        if (STOP || (beat[3] && ILL)) begin
                            state <= ST_DRAIN;
                        end
                    end
                end

                ST_DRAIN: begin
                    if (beat[7]) begin
                        CYC_CNT <= CYC_CNT + 8'd1;
                        state   <= ST_IDLE;
                        beat    <= 8'd0;
                        RUN     <= 1'b0;
                    end else begin
                        beat <= {beat[6:0], beat[7]};
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    beat  <= 8'd0;
                    RUN   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timing_gen.sv
// tb/tb_timing_gen.sv - self-checking bench for timing_gen against a beat-index reference model

module tb_timing_gen;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       START = 1'b0;
    logic       STOP = 1'b0;
    logic       IIR = 1'b0;
    logic [2:0] IR_OP = 3'd0;
    logic       T0, T1, T2, T3, T4, T5, T6, T7;
    logic       LD, ADD, SUB, AND, OR, ILL, RUN;
    logic [7:0] CYC_CNT;

    int checks = 0;
    int errors = 0;

    // Reference model: beat index (-1 when idle), drain flag, cycle count, opcode.
    int m_beat  = -1;
    bit m_drain = 1'b0;
    int m_cnt   = 0;
    int m_op    = 0;

    logic [7:0] t_obs;
    logic [5:0] dec_obs;
    assign t_obs   = {T7, T6, T5, T4, T3, T2, T1, T0};
    assign dec_obs = {LD, ADD, SUB, AND, OR, ILL};

    timing_gen #(.OP_W(3)) dut (
        .CLK(CLK), .RST(RST), .START(START), .STOP(STOP), .IIR(IIR), .IR_OP(IR_OP),
        .T0(T0), .T1(T1), .T2(T2), .T3(T3), .T4(T4), .T5(T5), .T6(T6), .T7(T7),
        .LD(LD), .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR), .ILL(ILL),
        .RUN(RUN), .CYC_CNT(CYC_CNT)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] exp_t();
        logic [7:0] one;
        one = 8'd1;
        return (m_beat < 0) ? 8'd0 : (one << m_beat);
    endfunction

    function automatic logic [5:0] exp_dec();
        logic [5:0] d;
        d = 6'd0;
        case (m_op)
            1: d = 6'b100000;
            2: d = 6'b010000;
            3: d = 6'b001000;
            4: d = 6'b000100;
            5: d = 6'b000010;
            6, 7: d = 6'b000001;
            default: d = 6'd0;
        endcase
        return d;
    endfunction

    task automatic model_reset();
        m_beat  = -1;
        m_drain = 1'b0;
        m_cnt   = 0;
        m_op    = 0;
    endtask

    task automatic model_edge(input bit s, input bit p, input bit i, input int op);
        bit was_ill;
        bit last;
        was_ill = (m_op >= 6);
        if (i) m_op = op;
        if (m_beat < 0) begin
            if (s && !p) begin
                m_beat  = 0;
                m_drain = 1'b0;
            end
        end else begin
            last = (m_beat == 7);
            if (last) m_cnt = (m_cnt + 1) % 256;
            if (last && (m_drain || p)) begin
                m_beat = -1;
            end else begin
                if (p || (m_beat == 3 && was_ill)) m_drain = 1'b1;
                m_beat = (m_beat + 1) % 8;
            end
        end
    endtask

    task automatic tick(input bit s, input bit p, input bit i, input logic [2:0] op);
        START = s;
        STOP  = p;
        IIR   = i;
        IR_OP = op;
        @(posedge CLK);
        model_edge(s, p, i, int'(op));
        #1;
        START = 1'b0;
        STOP  = 1'b0;
        IIR   = 1'b0;
    endtask

    task automatic go_idle();
        tick(1'b0, 1'b1, 1'b0, 3'd0);
        for (int k = 0; k < 9 && m_beat >= 0; k++) tick(1'b0, 1'b0, 1'b0, 3'd0);
        checks++;
        if (RUN !== 1'b0 || t_obs !== 8'd0) begin
            errors++;
            $display("FAIL go_idle: RUN=%b T=%b, required RUN=0 T=00000000", RUN, t_obs);
        end
    endtask

    task automatic mid_cycle_reset();
        #3;
        RST = 1'b1;
        model_reset();
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        model_reset();
        checks++;
        if (t_obs !== 8'd0 || RUN !== 1'b0 || CYC_CNT !== 8'd0 || dec_obs !== 6'd0) begin
            errors++;
            $display("FAIL reset_state: T=%b RUN=%b CNT=%0d DEC=%b, required all zero",
                     t_obs, RUN, CYC_CNT, dec_obs);
        end
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    task automatic test_ld_walk();
        tick(1'b0, 1'b0, 1'b1, 3'b001);
        checks++;
        if (dec_obs !== 6'b100000) begin
            errors++;
            $display("FAIL ld_decode: DEC=%b, required 100000", dec_obs);
        end
        tick(1'b1, 1'b0, 1'b0, 3'd0);
        checks++;
        if (t_obs !== 8'b0000_0001 || RUN !== 1'b1) begin
            errors++;
            $display("FAIL ld_start: T=%b RUN=%b, required T=00000001 RUN=1", t_obs, RUN);
        end
        for (int k = 1; k < 8; k++) begin
            tick(1'b0, 1'b0, 1'b0, 3'd0);
            checks++;
            if (t_obs !== exp_t() || t_obs !== (8'd1 << k)) begin
                errors++;
                $display("FAIL ld_walk beat %0d: T=%b, required %b", k, t_obs, exp_t());
            end
        end
        tick(1'b0, 1'b0, 1'b0, 3'd0);
        checks++;
        if (t_obs !== 8'b0000_0001 || CYC_CNT !== 8'd1 || RUN !== 1'b1) begin
            errors++;
            $display("FAIL ld_wrap: T=%b CNT=%0d RUN=%b, required T=00000001 CNT=1 RUN=1",
                     t_obs, CYC_CNT, RUN);
        end
        go_idle();
    endtask

    task automatic test_stop_drain();
        logic [7:0] cnt_exp;
        tick(1'b0, 1'b0, 1'b1, 3'b010);
        tick(1'b1, 1'b0, 1'b0, 3'd0);
        tick(1'b0, 1'b0, 1'b0, 3'd0);
        tick(1'b0, 1'b0, 1'b0, 3'd0);
        checks++;
        if (t_obs !== 8'b0000_0100 || dec_obs !== 6'b010000) begin
            errors++;
            $display("FAIL stop_at_t2: T=%b DEC=%b, required T=00000100 DEC=010000", t_obs, dec_obs);
        end
        cnt_exp = 8'((m_cnt + 1) % 256);
        tick(1'b0, 1'b1, 1'b0, 3'd0);
        for (int k = 3; k < 8; k++) begin
            checks++;
            if (t_obs !== (8'd1 << k) || RUN !== 1'b1) begin
                errors++;
                $display("FAIL drain_beat %0d: T=%b RUN=%b, required T=%b RUN=1",
                         k, t_obs, RUN, 8'd1 << k);
            end
            tick(1'b0, 1'b0, 1'b0, 3'd0);
        end
        checks++;
        if (t_obs !== 8'd0 || RUN !== 1'b0 || CYC_CNT !== cnt_exp) begin
            errors++;
            $display("FAIL drain_end: T=%b RUN=%b CNT=%0d, required T=0 RUN=0 CNT=%0d",
                     t_obs, RUN, CYC_CNT, cnt_exp);
        end
    endtask

    task automatic test_illegal();
        tick(1'b0, 1'b0, 1'b1, 3'b110);
        checks++;
        if (dec_obs !== 6'b000001) begin
            errors++;
            $display("FAIL ill_decode: DEC=%b, required 000001", dec_obs);
        end
        tick(1'b1, 1'b0, 1'b0, 3'd0);
        for (int k = 1; k < 8; k++) begin
            tick(1'b0, 1'b0, 1'b0, 3'd0);
            checks++;
            if (t_obs !== (8'd1 << k) || RUN !== 1'b1) begin
                errors++;
                $display("FAIL ill_beat %0d: T=%b RUN=%b, required T=%b RUN=1",
                         k, t_obs, RUN, 8'd1 << k);
            end
        end
        tick(1'b0, 1'b0, 1'b0, 3'd0);
        checks++;
        if (t_obs !== 8'd0 || RUN !== 1'b0 || t_obs !== exp_t()) begin
            errors++;
            $display("FAIL ill_idle: T=%b RUN=%b, required T=00000000 RUN=0", t_obs, RUN);
        end
    endtask

    task automatic test_start_ignored();
        tick(1'b0, 1'b0, 1'b1, 3'b001);
        tick(1'b1, 1'b1, 1'b0, 3'd0);
        checks++;
        if (t_obs !== 8'd0 || RUN !== 1'b0) begin
            errors++;
            $display("FAIL start_stop_idle: T=%b RUN=%b, required T=0 RUN=0", t_obs, RUN);
        end
        tick(1'b1, 1'b0, 1'b0, 3'd0);
        for (int k = 0; k < 5; k++) tick(1'b0, 1'b0, 1'b0, 3'd0);
        tick(1'b1, 1'b0, 1'b0, 3'd0);
        checks++;
        if (t_obs !== 8'b0100_0000) begin
            errors++;
            $display("FAIL start_in_run_t6: T=%b, required 01000000", t_obs);
        end
        tick(1'b1, 1'b0, 1'b0, 3'd0);
        tick(1'b0, 1'b0, 1'b0, 3'd0);
        checks++;
        if (t_obs !== 8'b0000_0001 || RUN !== 1'b1) begin
            errors++;
            $display("FAIL start_in_run_wrap: T=%b RUN=%b, required T=00000001 RUN=1", t_obs, RUN);
        end
        go_idle();
    endtask

    task automatic test_wrap();
        mid_cycle_reset();
        tick(1'b1, 1'b0, 1'b0, 3'd0);
        for (int k = 0; k < 255 * 8; k++) tick(1'b0, 1'b0, 1'b0, 3'd0);
        checks++;
        if (CYC_CNT !== 8'd255) begin
            errors++;
            $display("FAIL cnt_255: CNT=%0d, required 255", CYC_CNT);
        end
        for (int k = 0; k < 8; k++) tick(1'b0, 1'b0, 1'b0, 3'd0);
        checks++;
        if (CYC_CNT !== 8'd0 || t_obs !== 8'b0000_0001) begin
            errors++;
            $display("FAIL cnt_wrap: CNT=%0d T=%b, required CNT=0 T=00000001", CYC_CNT, t_obs);
        end
        go_idle();
    endtask

    task automatic test_async_reset();
        tick(1'b0, 1'b0, 1'b1, 3'b011);
        tick(1'b1, 1'b0, 1'b0, 3'd0);
        for (int k = 0; k < 4; k++) tick(1'b0, 1'b0, 1'b0, 3'd0);
        checks++;
        if (t_obs !== 8'b0001_0000 || dec_obs !== 6'b001000) begin
            errors++;
            $display("FAIL pre_reset: T=%b DEC=%b, required T=00010000 DEC=001000", t_obs, dec_obs);
        end
        #3;
        RST = 1'b1;
        model_reset();
        #1;
        checks++;
        if (t_obs !== 8'd0 || RUN !== 1'b0 || CYC_CNT !== 8'd0 || dec_obs !== 6'd0) begin
            errors++;
            $display("FAIL async_reset: T=%b RUN=%b CNT=%0d DEC=%b, required all zero",
                     t_obs, RUN, CYC_CNT, dec_obs);
        end
        @(posedge CLK);
        #1;
        RST = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick(1'b0, 1'b0, 1'b0, 3'd0);
            checks++;
            if (t_obs !== 8'd0 || RUN !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_quiet %0d: T=%b RUN=%b, required T=0 RUN=0", k, t_obs, RUN);
            end
        end
    endtask

    task automatic test_random();
        bit s, p, i;
        logic [2:0] op;
        for (int n = 0; n < 1500; n++) begin
            s  = ($urandom_range(3) == 0);
            p  = ($urandom_range(11) == 0);
            i  = ($urandom_range(5) == 0);
            op = 3'($urandom_range(7));
            tick(s, p, i, op);
            checks++;
            if (t_obs !== exp_t() || RUN !== (m_beat >= 0) || CYC_CNT !== 8'(m_cnt)
                || dec_obs !== exp_dec()) begin
                errors++;
                $display("FAIL random step %0d: T=%b RUN=%b CNT=%0d DEC=%b, required T=%b RUN=%b CNT=%0d DEC=%b",
                         n, t_obs, RUN, CYC_CNT, dec_obs, exp_t(), (m_beat >= 0), m_cnt, exp_dec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_ld_walk();
        test_stop_drain();
        test_illegal();
        test_start_ignored();
        test_wrap();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
